// File: rtl/basic_gate_pkg.sv
// rtl/basic_gate_pkg.sv - shared gate indices, BIST state type and golden truth table
package basic_gate_pkg;

    localparam int GATE_NOT  = 0;
    localparam int GATE_AND  = 1;
    localparam int GATE_NAND = 2;
    localparam int GATE_OR   = 3;
    localparam int GATE_NOR  = 4;
    localparam int GATE_XOR  = 5;
    localparam int GATE_XNOR = 6;
    localparam int NUM_GATES = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_FINISH = 3'd4
    } bist_state_t;

    // Expected datapath outputs for one (a,b) input vector
    function automatic logic [NUM_GATES-1:0] golden_gates(input logic a, input logic b);
        logic [NUM_GATES-1:0] g;
        g            = '0;
        g[GATE_NOT]  = ~a;
        g[GATE_AND]  = a & b;
        g[GATE_NAND] = ~(a & b);
        g[GATE_OR]   = a | b;
        g[GATE_NOR]  = ~(a | b);
        g[GATE_XOR]  = a ^ b;
        g[GATE_XNOR] = ~(a ^ b);
        return g;
    endfunction

endpackage

// File: rtl/basic_gate_bist_ctrl.sv
// rtl/basic_gate_bist_ctrl.sv - BIST sequencer sweeping the 2-input gate block against a golden table
module basic_gate_bist_ctrl
    import basic_gate_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_PASSES    = 1,
    parameter int CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_GATES-1:0] gate_out,
    output logic                 dut_a,
    output logic                 dut_b,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 aborted,
    output logic [NUM_GATES-1:0] err_mask,
    output logic [CNT_W-1:0]     err_count
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0]    LAST_PASS   = PW'(NUM_PASSES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    bist_state_t          state_q;
    logic [1:0]           idx_q;
    logic [PW-1:0]        pass_cnt_q;
    logic [SW-1:0]        settle_q;
    logic                 dut_a_q;
    logic                 dut_b_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic                 aborted_q;
    logic [NUM_GATES-1:0] err_mask_q;
    logic [CNT_W-1:0]     err_count_q;

    logic [NUM_GATES-1:0] diff_d;
    logic [NUM_GATES-1:0] err_mask_d;
    logic [CNT_W-1:0]     err_count_d;
    logic [1:0]           idx_d;
    logic                 wrap_d;

    // Compare the sampled gate outputs with the expected vector and form the updated tallies
    always_comb begin
        diff_d      = gate_out ^ golden_gates(idx_q[1], idx_q[0]);
        err_mask_d  = err_mask_q | diff_d;
        err_count_d = err_count_q;
        if ((diff_d != '0) && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + 1'b1;
        end
        idx_d  = idx_q + 2'd1;
        wrap_d = (idx_q == 2'd3);
    end

    // Sequencer FSM; every output is registered alongside the state it belongs to
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            pass_cnt_q  <= '0;
            settle_q    <= '0;
            dut_a_q     <= 1'b0;
            dut_b_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            aborted_q   <= 1'b0;
            err_mask_q  <= '0;
            err_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!abort && start) begin
                        state_q     <= ST_APPLY;
                        idx_q       <= '0;
                        pass_cnt_q  <= '0;
                        err_mask_q  <= '0;
                        err_count_q <= '0;
                        pass_q      <= 1'b0;
                        aborted_q   <= 1'b0;
                        busy_q      <= 1'b1;
                        dut_a_q     <= 1'b0;
                        dut_b_q     <= 1'b0;
                    end
                end
                ST_APPLY, ST_SETTLE, ST_SAMPLE: begin
                    if (abort) begin
                        // Partial tallies stay visible; an in-flight sample is dropped
                        state_q   <= ST_IDLE;
                        aborted_q <= 1'b1;
                        pass_q    <= 1'b0;
                        busy_q    <= 1'b0;
                        dut_a_q   <= 1'b0;
                        dut_b_q   <= 1'b0;
                    end else if (state_q == ST_APPLY) begin
                        settle_q <= SETTLE_LOAD;
                        state_q  <= ST_SETTLE;
                    end else if (state_q == ST_SETTLE) begin
                        if (settle_q == '0) begin
                            state_q <= ST_SAMPLE;
                        end else begin
                            settle_q <= settle_q - 1'b1;
                        end
                    end else begin
                        err_mask_q  <= err_mask_d;
                        err_count_q <= err_count_d;
                        idx_q       <= idx_d;
                        if (wrap_d) begin
                            pass_cnt_q <= pass_cnt_q + 1'b1;
                        end
                        if (wrap_d && (pass_cnt_q == LAST_PASS)) begin
                            state_q <= ST_FINISH;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            dut_a_q <= 1'b0;
                            dut_b_q <= 1'b0;
                        end else begin
                            state_q <= ST_APPLY;
                            dut_a_q <= idx_d[1];
                            dut_b_q <= idx_d[0];
                        end
                    end
                end
                ST_FINISH: begin
                    pass_q  <= (err_mask_q == '0);
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    dut_a_q <= 1'b0;
                    dut_b_q <= 1'b0;
                end
            endcase
        end
    end

    assign dut_a     = dut_a_q;
    assign dut_b     = dut_b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign aborted   = aborted_q;
    assign err_mask  = err_mask_q;
    assign err_count = err_count_q;

endmodule
